// File: rtl/board_clock_control_pkg.sv
// Shared encodings and defaults for the board push-button conditioning and CPU clock control.
package board_clock_control_pkg;

    typedef enum logic [1:0] {
        CLK_MODE_FULL = 2'b00,
        CLK_MODE_DIV  = 2'b01,
        CLK_MODE_STEP = 2'b10,
        CLK_MODE_HALT = 2'b11
    } clk_mode_e;

    typedef enum logic [1:0] {
        DEB_RELEASED,
        DEB_CHECK_PRESS,
        DEB_PRESSED,
        DEB_CHECK_RELEASE
    } deb_state_e;

    localparam int KEY_IDX_RESET = 0;
    localparam int KEY_IDX_STEP  = 1;

    // 10 ms at 50 MHz on the board; the short value keeps simulations fast.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/board_clock_control_key_debouncer.sv
// One push-button: two-flop synchroniser, debounce FSM with stability counter,
// debounced active-high level and a single-cycle press pulse.
module board_clock_control_key_debouncer
    import board_clock_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic key_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             pressed;
    deb_state_e       state;
    deb_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;

    // Synchroniser stage: flops idle at 1 so a reset looks like a released button.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed = ~sync_p1;

    // Debounce stage: state, counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= DEB_RELEASED;
            cnt       <= '0;
            key_level <= 1'b0;
            key_press <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_level <= level_nxt;
            key_press <= press_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = key_level;
        press_nxt = 1'b0;
        case (state)
            DEB_RELEASED: begin
                if (pressed) begin
                    state_nxt = DEB_CHECK_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DEB_CHECK_PRESS: begin
                if (!pressed) begin
                    state_nxt = DEB_RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DEB_PRESSED;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DEB_PRESSED: begin
                if (!pressed) begin
                    state_nxt = DEB_CHECK_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            DEB_CHECK_RELEASE: begin
                // Release is silent: only the level drops, no pulse.
                if (pressed) begin
                    state_nxt = DEB_PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DEB_RELEASED;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = DEB_RELEASED;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/board_clock_control.sv
// Board button conditioning plus CPU clock-enable / reset generation
// (full speed, divided, single-step, halt).
module board_clock_control
    import board_clock_control_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DIV_WIDTH       = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [1:0]          clock_mode,
    input  logic [4:0]          div_exp,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                cpu_clock_enable,
    output logic                cpu_reset
);

    // Last divider value of a period of 2^(e+1), saturating at 2^DIV_WIDTH.
    function automatic logic [DIV_WIDTH-1:0] div_terminal(input logic [4:0] e);
        if (int'(e) + 1 >= DIV_WIDTH) begin
            return '1;
        end
        return (DIV_WIDTH'(1) << (int'(e) + 1)) - DIV_WIDTH'(1);
    endfunction

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        board_clock_control_key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock     (clock),
            .reset     (reset),
            .key_n     (key_n[k]),
            .key_level (key_level[k]),
            .key_press (key_press[k])
        );
    end

    clk_mode_e            mode_p0;
    logic [4:0]           dexp_p0;
    logic [DIV_WIDTH-1:0] div_cnt_p0;
    logic [DIV_WIDTH-1:0] div_term;
    logic                 div_hit;
    logic                 cfg_chg;
    logic                 step_hit;
    logic                 en_nxt;

    assign cfg_chg  = (clk_mode_e'(clock_mode) != mode_p0) || (div_exp != dexp_p0);
    assign div_term = div_terminal(dexp_p0);
    assign div_hit  = (div_cnt_p0 == div_term);
    // A step press only counts when the mode being entered (or kept) is step.
    assign step_hit = key_press[KEY_IDX_STEP] && (clk_mode_e'(clock_mode) == CLK_MODE_STEP);

    always_comb begin
        en_nxt = 1'b0;
        case (mode_p0)
            CLK_MODE_FULL: en_nxt = 1'b1;
            CLK_MODE_DIV:  en_nxt = div_hit && !cfg_chg;
            default:       en_nxt = 1'b0;
        endcase
        if (step_hit) begin
            en_nxt = 1'b1;
        end
        if (cpu_reset) begin
            en_nxt = 1'b1;
        end
    end

    // Configuration stage: mode register and free-running divider.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_p0    <= CLK_MODE_FULL;
            dexp_p0    <= '0;
            div_cnt_p0 <= '0;
        end else begin
            mode_p0    <= clk_mode_e'(clock_mode);
            dexp_p0    <= div_exp;
            div_cnt_p0 <= (cfg_chg || div_hit) ? '0 : div_cnt_p0 + DIV_WIDTH'(1);
        end
    end

    // Output stage: core reset request and clock enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_reset        <= 1'b1;
            cpu_clock_enable <= 1'b0;
        end else begin
            cpu_reset        <= key_level[KEY_IDX_RESET];
            cpu_clock_enable <= en_nxt;
        end
    end

endmodule
